// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and the per-stage control bundle for the pipeline controller.
package pipe_ctrl_pkg;

  // Control bundles carry register indices at this width; REG_ADDR_W must match it.
  localparam int CTRL_WREG_W = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MULT  = 6'h18;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_RTYPE = 2'b10
  } alu_op_e;

  typedef struct packed {
    logic                   alu_src;
    alu_op_e                alu_op;
    logic                   link;
    logic                   mem_read;
    logic                   mem_write;
    logic                   reg_write;
    logic                   mem_to_reg;
    logic [CTRL_WREG_W-1:0] wreg;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '{
    alu_src:    1'b0,
    alu_op:     ALU_ADD,
    link:       1'b0,
    mem_read:   1'b0,
    mem_write:  1'b0,
    reg_write:  1'b0,
    mem_to_reg: 1'b0,
    wreg:       '0
  };

endpackage

// File: rtl/pipe_ctrl_decode.sv
// Combinational ID-stage decoder: opcode/funct to control bundle plus redirect class flags.
// The mult flag port exists only when CTRL_MULDIV_EN is defined.
module pipe_ctrl_decode
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int RA_ADDR    = 31
) (
  input  logic [5:0]            id_opcode,
  input  logic [5:0]            id_funct,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  output ctrl_t                 ctrl,
  output logic                  is_beq,
  output logic                  is_bne,
  output logic                  is_jump,
  output logic                  is_jump_r,
  output logic                  reads_rt
`ifdef CTRL_MULDIV_EN
  , output logic                is_mult
`endif
);

  always_comb begin
    ctrl      = CTRL_BUBBLE;
    is_beq    = 1'b0;
    is_bne    = 1'b0;
    is_jump   = 1'b0;
    is_jump_r = 1'b0;
    reads_rt  = 1'b0;
    case (id_opcode)
      OP_RTYPE: begin
        reads_rt = 1'b1;
        case (id_funct)
          FN_JR: is_jump_r = 1'b1;
          FN_JALR: begin
            is_jump_r      = 1'b1;
            ctrl.reg_write = 1'b1;
            ctrl.link      = 1'b1;
            ctrl.wreg      = CTRL_WREG_W'(id_rd);
          end
          default: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = ALU_RTYPE;
            ctrl.wreg      = CTRL_WREG_W'(id_rd);
          end
        endcase
      end
      OP_BEQ: begin
        is_beq      = 1'b1;
        reads_rt    = 1'b1;
        ctrl.alu_op = ALU_SUB;
      end
      OP_BNE: begin
        is_bne      = 1'b1;
        reads_rt    = 1'b1;
        ctrl.alu_op = ALU_SUB;
      end
      OP_J: is_jump = 1'b1;
      OP_JAL: begin
        is_jump        = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.link      = 1'b1;
        ctrl.wreg      = CTRL_WREG_W'(RA_ADDR);
      end
      OP_LW: begin
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.wreg       = CTRL_WREG_W'(id_rt);
      end
      OP_SW: begin
        reads_rt       = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
      end
      default: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.wreg      = CTRL_WREG_W'(id_rt);
      end
    endcase
    // $0 is hardwired; never let a write to it look like a producer to the hazard logic.
    if (ctrl.wreg == '0) ctrl.reg_write = 1'b0;
  end

`ifdef CTRL_MULDIV_EN
  assign is_mult = (id_opcode == OP_RTYPE) && (id_funct == FN_MULT);
`endif

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control: ID decode, ID/EX, EX/MEM, MEM/WB control registers, hazard stall/flush.
// Define CTRL_MULDIV_EN to add the multi-cycle multiply occupancy counter and ex_mul_busy.
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int RA_ADDR    = 31,
  parameter int MUL_LAT    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [5:0]            id_opcode,
  input  logic [5:0]            id_funct,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_eq,
  input  logic                  mem_stall,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  if_flush,
  output logic                  pc_src,
  output logic                  jump,
  output logic                  jump_r,
  output logic                  ex_alu_src,
  output logic [1:0]            ex_alu_op,
  output logic [REG_ADDR_W-1:0] ex_wreg,
  output logic                  ex_link,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [REG_ADDR_W-1:0] mem_wreg,
  output logic                  wb_reg_write,
  output logic                  wb_mem_to_reg,
  output logic [REG_ADDR_W-1:0] wb_wreg
`ifdef CTRL_MULDIV_EN
  , output logic                ex_mul_busy
`endif
);

  if (MUL_LAT < 2 || MUL_LAT > 15) begin : g_bad_mul_lat
    $error("pipe_ctrl_unit: MUL_LAT must be in 2..15");
  end

  ctrl_t                  dec_ctrl;
  logic                   dec_beq, dec_bne, dec_jump, dec_jump_r, dec_reads_rt;
  ctrl_t                  idex_q, exmem_q;
  logic                   wb_reg_write_q, wb_mem_to_reg_q;
  logic [CTRL_WREG_W-1:0] wb_wreg_q;
  logic [CTRL_WREG_W-1:0] rs_w, rt_w;
  logic                   load_use, br_haz, data_haz, mul_busy, stall, is_branch;
  logic                   ex_hit, mem_hit;

`ifdef CTRL_MULDIV_EN
  logic       dec_mult;
  logic [3:0] mul_cnt_q;
`endif

  pipe_ctrl_decode #(
    .REG_ADDR_W (REG_ADDR_W),
    .RA_ADDR    (RA_ADDR)
  ) u_decode (
    .id_opcode (id_opcode),
    .id_funct  (id_funct),
    .id_rt     (id_rt),
    .id_rd     (id_rd),
    .ctrl      (dec_ctrl),
    .is_beq    (dec_beq),
    .is_bne    (dec_bne),
    .is_jump   (dec_jump),
    .is_jump_r (dec_jump_r),
    .reads_rt  (dec_reads_rt)
`ifdef CTRL_MULDIV_EN
    , .is_mult (dec_mult)
`endif
  );

`ifdef CTRL_MULDIV_EN
  assign mul_busy    = (mul_cnt_q != 4'd0);
  assign ex_mul_busy = mul_busy;
`else
  assign mul_busy = 1'b0;
`endif

  always_comb begin
    rs_w      = CTRL_WREG_W'(id_rs);
    rt_w      = CTRL_WREG_W'(id_rt);
    is_branch = dec_beq | dec_bne | dec_jump_r;
    load_use  = idex_q.mem_read && (idex_q.wreg != '0) &&
                ((idex_q.wreg == rs_w) || (dec_reads_rt && (idex_q.wreg == rt_w)));
    // jr/jalr only source rs; beq/bne compare both operands in ID.
    ex_hit    = (idex_q.wreg == rs_w) || ((dec_beq | dec_bne) && (idex_q.wreg == rt_w));
    mem_hit   = (exmem_q.wreg == rs_w) || ((dec_beq | dec_bne) && (exmem_q.wreg == rt_w));
    br_haz    = is_branch && ((idex_q.reg_write && ex_hit) || (exmem_q.mem_read && mem_hit));
    data_haz  = load_use | br_haz;
    stall     = mem_stall | mul_busy | data_haz;

    pc_write   = !stall;
    ifid_write = !stall;
    pc_src     = !stall && ((dec_beq && id_eq) || (dec_bne && !id_eq));
    jump       = !stall && dec_jump;
    jump_r     = !stall && dec_jump_r;
    if_flush   = pc_src | jump | jump_r;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_q          <= CTRL_BUBBLE;
      exmem_q         <= CTRL_BUBBLE;
      wb_reg_write_q  <= 1'b0;
      wb_mem_to_reg_q <= 1'b0;
      wb_wreg_q       <= '0;
    end else if (!mem_stall) begin
      wb_reg_write_q  <= exmem_q.reg_write;
      wb_mem_to_reg_q <= exmem_q.mem_to_reg;
      wb_wreg_q       <= exmem_q.wreg;
      exmem_q         <= mul_busy ? CTRL_BUBBLE : idex_q;
      if (!mul_busy) idex_q <= data_haz ? CTRL_BUBBLE : dec_ctrl;
    end
  end

`ifdef CTRL_MULDIV_EN
  // The mult occupies EX for MUL_LAT cycles: the load cycle plus MUL_LAT-1 busy cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_cnt_q <= 4'd0;
    end else if (!mem_stall) begin
      if (mul_busy) mul_cnt_q <= mul_cnt_q - 4'd1;
      else if (dec_mult && !data_haz) mul_cnt_q <= 4'(MUL_LAT - 1);
    end
  end
`endif

  assign ex_alu_src    = idex_q.alu_src;
  assign ex_alu_op     = idex_q.alu_op;
  assign ex_wreg       = idex_q.wreg[REG_ADDR_W-1:0];
  assign ex_link       = idex_q.link;
  assign mem_read      = exmem_q.mem_read;
  assign mem_write     = exmem_q.mem_write;
  assign mem_wreg      = exmem_q.wreg[REG_ADDR_W-1:0];
  assign wb_reg_write  = wb_reg_write_q;
  assign wb_mem_to_reg = wb_mem_to_reg_q;
  assign wb_wreg       = wb_wreg_q[REG_ADDR_W-1:0];

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: decode, load-use, branch hazards, redirects, mem_stall, reset.
module tb_pipe_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] id_opcode, id_funct;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       id_eq, mem_stall;
  logic       pc_write, ifid_write, if_flush, pc_src, jump, jump_r;
  logic       ex_alu_src, ex_link, mem_read, mem_write, wb_reg_write, wb_mem_to_reg;
  logic [1:0] ex_alu_op;
  logic [4:0] ex_wreg, mem_wreg, wb_wreg;
`ifdef CTRL_MULDIV_EN
  logic       ex_mul_busy;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_ctrl_unit #(.REG_ADDR_W(5), .RA_ADDR(31), .MUL_LAT(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_opcode     (id_opcode),
    .id_funct      (id_funct),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_rd         (id_rd),
    .id_eq         (id_eq),
    .mem_stall     (mem_stall),
    .pc_write      (pc_write),
    .ifid_write    (ifid_write),
    .if_flush      (if_flush),
    .pc_src        (pc_src),
    .jump          (jump),
    .jump_r        (jump_r),
    .ex_alu_src    (ex_alu_src),
    .ex_alu_op     (ex_alu_op),
    .ex_wreg       (ex_wreg),
    .ex_link       (ex_link),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_wreg      (mem_wreg),
    .wb_reg_write  (wb_reg_write),
    .wb_mem_to_reg (wb_mem_to_reg),
    .wb_wreg       (wb_wreg)
`ifdef CTRL_MULDIV_EN
    , .ex_mul_busy (ex_mul_busy)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic instr(input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic eq);
    id_opcode = op; id_funct = fn; id_rs = rs; id_rt = rt; id_rd = rd; id_eq = eq;
    #1;
  endtask

  task automatic nop();
    instr(6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; mem_stall = 1'b0;
    nop();
    #11;
    chk("rst_pc_write", pc_write, 1);
    chk("rst_ifid_write", ifid_write, 1);
    chk("rst_if_flush", if_flush, 0);
    chk("rst_ex_wreg", ex_wreg, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_wb_reg_write", wb_reg_write, 0);
    rst_n = 1'b1;
    tick();

    // lw $8 then add $9,$8,$1: one load-use stall, bubble in EX
    instr(6'h23, 6'h00, 5'd1, 5'd8, 5'd0, 1'b0);
    chk("lw_no_stall", pc_write, 1);
    tick();
    instr(6'h00, 6'h20, 5'd8, 5'd1, 5'd9, 1'b0);
    chk("lu_ex_wreg", ex_wreg, 8);
    chk("lu_ex_alu_src", ex_alu_src, 1);
    chk("lu_pc_write", pc_write, 0);
    chk("lu_ifid_write", ifid_write, 0);
    tick();
    chk("lu_bubble_wreg", ex_wreg, 0);
    chk("lu_bubble_alu_op", ex_alu_op, 0);
    chk("lu_mem_read", mem_read, 1);
    chk("lu_mem_wreg", mem_wreg, 8);
    chk("lu_resume", pc_write, 1);
    tick();
    nop();
    chk("add_ex_wreg", ex_wreg, 9);
    chk("add_ex_alu_op", ex_alu_op, 2);
    chk("lw_wb_wreg", wb_wreg, 8);
    chk("lw_wb_m2r", wb_mem_to_reg, 1);
    chk("lw_wb_rw", wb_reg_write, 1);
    tick();

    // addi $5 then beq $5,$6 taken: one stall, then redirect
    instr(6'h08, 6'h00, 5'd0, 5'd5, 5'd0, 1'b0);
    tick();
    instr(6'h04, 6'h00, 5'd5, 5'd6, 5'd0, 1'b1);
    chk("br_haz_pc_write", pc_write, 0);
    chk("br_haz_pc_src", pc_src, 0);
    chk("br_haz_flush", if_flush, 0);
    tick();
    chk("beq_pc_src", pc_src, 1);
    chk("beq_flush", if_flush, 1);
    chk("beq_pc_write", pc_write, 1);
    tick();

    // bne: not taken when equal, taken when not equal
    instr(6'h05, 6'h00, 5'd2, 5'd3, 5'd0, 1'b1);
    chk("bne_eq_pc_src", pc_src, 0);
    chk("bne_eq_flush", if_flush, 0);
    instr(6'h05, 6'h00, 5'd2, 5'd3, 5'd0, 1'b0);
    chk("bne_ne_pc_src", pc_src, 1);

    // jal: jump now, link to $31 reaches WB three edges later
    instr(6'h03, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
    chk("jal_jump", jump, 1);
    chk("jal_flush", if_flush, 1);
    chk("jal_jump_r", jump_r, 0);
    tick();
    nop();
    chk("jal_ex_link", ex_link, 1);
    chk("jal_ex_wreg", ex_wreg, 31);
    tick();
    tick();
    chk("jal_wb_wreg", wb_wreg, 31);
    chk("jal_wb_rw", wb_reg_write, 1);

    // jr: register redirect, no writeback
    instr(6'h00, 6'h08, 5'd4, 5'd0, 5'd0, 1'b0);
    chk("jr_jump_r", jump_r, 1);
    chk("jr_flush", if_flush, 1);
    tick();
    nop();
    chk("jr_ex_wreg", ex_wreg, 0);
    tick();
    tick();

    // mem_stall held 3 cycles during lw/add
    instr(6'h23, 6'h00, 5'd1, 5'd8, 5'd0, 1'b0);
    tick();
    instr(6'h00, 6'h20, 5'd8, 5'd1, 5'd9, 1'b0);
    mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ms_pc_write", pc_write, 0);
      chk("ms_ex_wreg", ex_wreg, 8);
      chk("ms_mem_read", mem_read, 0);
      chk("ms_wb_rw", wb_reg_write, 0);
      tick();
    end
    mem_stall = 1'b0;
    #1;
    chk("ms_rel_lu_stall", pc_write, 0);
    chk("ms_rel_ex_wreg", ex_wreg, 8);
    tick();
    chk("ms_bubble", ex_wreg, 0);
    chk("ms_mem_wreg", mem_wreg, 8);
    tick();
    nop();
    chk("ms_add_ex", ex_wreg, 9);
    tick();
    tick();

    // mem_stall suppresses redirect
    instr(6'h02, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
    mem_stall = 1'b1;
    #1;
    chk("ms_j_jump", jump, 0);
    chk("ms_j_flush", if_flush, 0);
    mem_stall = 1'b0;
    #1;
    chk("j_jump", jump, 1);
    tick();
    nop();

    // sw reads rt: load-use through rt
    instr(6'h23, 6'h00, 5'd1, 5'd7, 5'd0, 1'b0);
    tick();
    instr(6'h2b, 6'h00, 5'd2, 5'd7, 5'd0, 1'b0);
    chk("sw_lu_stall", pc_write, 0);
    // reset mid-stall aborts it
    rst_n = 1'b0;
    #1;
    chk("rst_mid_pc_write", pc_write, 1);
    chk("rst_mid_ex_wreg", ex_wreg, 0);
    nop();
    rst_n = 1'b1;
    tick();

    // write to $0 is squashed
    instr(6'h08, 6'h00, 5'd1, 5'd0, 5'd0, 1'b0);
    tick();
    nop();
    tick();
    tick();
    chk("r0_wb_rw", wb_reg_write, 0);

`ifdef CTRL_MULDIV_EN
    instr(6'h00, 6'h18, 5'd1, 5'd2, 5'd10, 1'b0);
    chk("mul_idle", ex_mul_busy, 0);
    tick();
    nop();
    for (int i = 0; i < 3; i++) begin
      chk("mul_busy", ex_mul_busy, 1);
      chk("mul_pc_write", pc_write, 0);
      chk("mul_ex_wreg", ex_wreg, 10);
      chk("mul_mem_bubble", mem_wreg, 0);
      tick();
    end
    chk("mul_done", ex_mul_busy, 0);
    chk("mul_done_pc_write", pc_write, 1);
    tick();
    chk("mul_mem_wreg", mem_wreg, 10);
    instr(6'h00, 6'h18, 5'd1, 5'd2, 5'd11, 1'b0);
    tick();
    nop();
    chk("mul2_busy", ex_mul_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mul_rst_busy", ex_mul_busy, 0);
    chk("mul_rst_pc_write", pc_write, 1);
    rst_n = 1'b1;
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
- Parametrised successor to the single-stage opcode decoder in the 5-stage MIPS pipeline.
- Decodes the ID-stage instruction and carries the control bundle through the ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use and branch-operand hazards, generates stall and flush signals, and honours a global data-memory stall.
- Sits between the IF/ID register and the datapath stage registers.

Parameters:
- REG_ADDR_W, 5, register-index width.
- RA_ADDR, 31, link register written by jal/jalr.
- MUL_LAT, 4, EX occupancy in cycles of a multiply; used only with CTRL_MULDIV_EN; legal range 2..15.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_opcode  in  6  instr[31:26].
- id_funct  in  6  instr[5:0].
- id_rs, id_rt, id_rd  in  REG_ADDR_W each  source and destination fields.
- id_eq  in  1  rs==rt compare result from ID (forwarded).
- mem_stall  in  1  data-cache miss; freezes the whole pipeline.
- pc_write  out  1  PC enable.
- ifid_write  out  1  IF/ID enable.
- if_flush  out  1  zero the IF/ID register.
- pc_src  out  1  take branch target.
- jump  out  1  take j/jal target.
- jump_r  out  1  take register target.
- ex_alu_src  out  1  EX control.
- ex_alu_op  out  2  EX control.
- ex_wreg  out  REG_ADDR_W  EX control; destination register.
- ex_link  out  1  EX control; write PC+8.
- mem_read  out  1  MEM control.
- mem_write  out  1  MEM control.
- mem_wreg  out  REG_ADDR_W  MEM control.
- wb_reg_write  out  1  WB control.
- wb_mem_to_reg  out  1  WB control.
- wb_wreg  out  REG_ADDR_W  WB control.

Behaviour:
- Decode (combinational, ID):
  - R-type (op 0): reg_write, alu_op=2'b10, dest=rd.
  - jr (funct 0x08): jump_r only; no writeback.
  - jalr (funct 0x09): jump_r, reg_write, link, dest=rd.
  - beq 0x04 / bne 0x05: branch, alu_op=2'b01.
  - j 0x02: jump.
  - jal 0x03: jump, reg_write, link, dest=RA_ADDR.
  - lw 0x23: mem_read, mem_to_reg, reg_write, alu_src, dest=rt.
  - sw 0x2b: mem_write, alu_src.
  - All other opcodes: alu_src, reg_write, alu_op=2'b00, dest=rt.
  - Any write to register 0 is squashed (reg_write forced 0).
- Hazards, in priority order:
  1. mem_stall=1:
     - pc_write=ifid_write=0.
     - All stage registers hold their values.
     - if_flush=pc_src=jump=jump_r=0.
  2. Load-use: ex stage is a load, ex_wreg!=0, and ex_wreg equals id_rs, or equals id_rt where the ID instruction reads rt (R-type, beq/bne, sw).
     - Stall one cycle: pc_write=ifid_write=0.
     - ID/EX loads a bubble (all control 0, wreg 0).
  3. Branch-operand: ID instruction is beq/bne/jr/jalr and either:
     - ex reg_write with ex_wreg equal to a branch source, or
     - a mem-stage load with mem_wreg equal to a branch source.
     Response is the same as load-use: stall plus bubble. Redirect outputs are 0 during any stall.
- Redirect (no stall):
  - Taken beq (id_eq=1) or bne (id_eq=0): pc_src=1, if_flush=1.
  - j/jal: jump=1, if_flush=1.
  - jr/jalr: jump_r=1, if_flush=1.
  - All combinational, same cycle.
- Pipeline: on each unstalled edge, control advances ID→EX→MEM→WB, one stage per cycle.
- Reset: all stage registers are 0 (bubbles). Combinational outputs are derived from the zeroed state, so pc_write=ifid_write=1 and all other outputs are 0. Reset mid-stall aborts the stall immediately.

Optional Feature:
- CTRL_MULDIV_EN defined:
  - R-type funct 0x18 (mult) entering EX loads a 4-bit busy counter with MUL_LAT-1.
  - While the counter is non-zero: ID stalls (pc_write=ifid_write=0), ID/EX holds its value, EX/MEM receives bubbles, and the counter decrements.
  - mem_stall freezes the counter.
  - Adds output ex_mul_busy (1 bit).
- Undefined:
  - funct 0x18 decodes as an ordinary R-type with no stall.
  - ex_mul_busy is absent.

Decomposition:
- Package pipe_ctrl_pkg:
  - Opcode/funct localparams.
  - ALU-op encodings.
  - Packed struct ctrl_t (alu_src, alu_op, link, mem_read, mem_write, reg_write, mem_to_reg, wreg).
  - Constant CTRL_BUBBLE.
- One natural sub-module: pipe_ctrl_decode, the combinational opcode/funct→ctrl_t decoder.
- Hazard logic and stage registers remain in the top module.

Test Plan:
- lw $8 followed by add $9,$8,$1 → one cycle with pc_write=0 and a bubble in EX; add reaches EX the next cycle with ex_wreg=9.
- addi $5 immediately followed by beq $5,$6 with id_eq=1 → one stall cycle, then pc_src=1, if_flush=1.
- bne with id_eq=1 → no redirect; pc_src=0, if_flush=0.
- jal → jump=1 and if_flush=1 same cycle; after 3 cycles wb_wreg=31 and wb_reg_write=1.
- mem_stall held 3 cycles during a lw/add sequence → all stage outputs constant, pc_write=0; sequence resumes exactly after release.
- With CTRL_MULDIV_EN, MUL_LAT=4: mult → ex_mul_busy=1 for 3 cycles, pc_write=0 for 3 cycles; rst_n low mid-count clears the counter.
